// File: rtl/rca_addsub_pipe.sv
// Pipelined ripple-carry add/subtract unit: one SLICE-bit ripple segment per stage,
// with a registered carry between stages and valid/ready flow control on both sides.
module rca_addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = WIDTH / SLICE;
  localparam int unsigned SW     = SLICE + 1;

  if (WIDTH == 0 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("rca_addsub_pipe: WIDTH must be a non-zero multiple of SLICE");
  end

  // Each stage word rotates right by SLICE: the slice just resolved enters at the top,
  // so after STAGES stages the operand-A word has become the result in natural order.
  logic [WIDTH-1:0]  r_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  r_nxt [STAGES];
  logic [WIDTH-1:0]  b_nxt [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_nxt;
  logic [STAGES-1:0] adv;
  logic              ovf_q;
  logic              zero_q;
  logic              ovf_nxt;
  logic              zero_nxt;

  // Bubble-collapsing advance: a stage moves if it is empty or its successor moves.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  // Per-stage slice ripple.
  always_comb begin
    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] b_in;
    logic             cy;
    logic [SW-1:0]    sum;
    int               prev;
    r_in     = '0;
    b_in     = '0;
    cy       = 1'b0;
    sum      = '0;
    prev     = 0;
    v_in     = '0;
    c_nxt    = '0;
    ovf_nxt  = 1'b0;
    zero_nxt = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      prev = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        r_in    = a;
        b_in    = b ^ {WIDTH{sub}};
        cy      = sub | c_in;
        v_in[k] = in_valid;
      end else begin
        r_in    = r_q[prev];
        b_in    = b_q[prev];
        cy      = c_q[prev];
        v_in[k] = v_q[prev];
      end
      sum      = SW'(r_in[SLICE-1:0]) + SW'(b_in[SLICE-1:0]) + SW'(cy);
      r_nxt[k] = (WIDTH'(sum[SLICE-1:0]) << (WIDTH - SLICE)) | (r_in >> SLICE);
      b_nxt[k] = (b_in >> SLICE) | (b_in << (WIDTH - SLICE));
      c_nxt[k] = sum[SLICE];
      if (k == int'(STAGES) - 1) begin
        // carry into the MSB is a^b^s at the MSB position
        ovf_nxt  = sum[SLICE] ^ r_in[SLICE-1] ^ b_in[SLICE-1] ^ sum[SLICE-1];
        zero_nxt = (r_nxt[k] == '0);
      end
    end
  end

  // Stage registers; data loads only with a valid beat so held outputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        r_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (adv[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            r_q[k] <= r_nxt[k];
            b_q[k] <= b_nxt[k];
            c_q[k] <= c_nxt[k];
          end
        end
      end
      if (adv[STAGES-1] && v_in[STAGES-1]) begin
        ovf_q  <= ovf_nxt;
        zero_q <= zero_nxt;
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign s         = r_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_rca_addsub_pipe.sv
// Bench for rca_addsub_pipe: default 32/8 instance plus a single-stage 16/16 instance,
// scoreboard of expected results checked in order against the DUT outputs.
module tb_rca_addsub_pipe;

  localparam int unsigned W   = 32;
  localparam int unsigned STG = 4;
  localparam int unsigned W1  = 16;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        ovf;
    logic        zero;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, ovf, zero;
  logic [W-1:0]  a, b, s;
  logic          in_valid1, in_ready1, c_in1, sub1, out_valid1, out_ready1, c_out1, ovf1, zero1;
  logic [W1-1:0] a1, b1, s1;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic smp_acc, smp_got, smp_in_ready, smp_out_ready, smp_out_valid;
  res_t smp_res;

  always #5 clk = ~clk;

  rca_addsub_pipe #(.WIDTH(W), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  rca_addsub_pipe #(.WIDTH(W1), .SLICE(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .c_out(c_out1), .ovf(ovf1), .zero(zero1)
  );

  // Reference: full-width add, signed overflow from operand/result sign bits.
  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic ci, input logic sb, input int w);
    logic [32:0] full;
    logic [31:0] mask, aa, bb;
    res_t        r;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
    aa     = ma & mask;
    bb     = (sb ? ~mb : mb) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + 33'(sb ? 1'b1 : ci);
    r.s    = full[31:0] & mask;
    r.c    = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.s[w-1] != aa[w-1]);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One clock of the 32-bit DUT: sample handshakes at negedge, record accepted beats.
  task automatic tick();
    @(negedge clk);
    smp_in_ready  = in_ready;
    smp_out_ready = out_ready;
    smp_out_valid = out_valid;
    smp_acc       = in_valid && in_ready;
    smp_got       = out_valid && out_ready;
    smp_res       = {s, c_out, ovf, zero};
    if (smp_acc) exp_q.push_back(model(a, b, c_in, sub, 32));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; a = '0; b = '0; c_in = 0; sub = 0; out_ready = 1;
    in_valid1 = 0; a1 = '0; b1 = '0; c_in1 = 0; sub1 = 0; out_ready1 = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_valid1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 00", {out_valid, out_valid1});
    end
    n_checks++;
    if ({s, c_out, ovf, zero} !== 35'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {s, c_out, ovf, zero});
    end
    rst_n = 1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, in_ready1} !== 2'b11) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 11", {in_ready, in_ready1});
    end
  endtask

  task automatic test_latency();
    int   n;
    res_t e;
    a = 32'h5; b = 32'h3; c_in = 0; sub = 0; out_ready = 1; in_valid = 1;
    tick();
    in_valid = 0;
    n_checks++;
    if (smp_acc !== 1'b1) begin
      n_fail++; $display("FAIL latency_accept: got %b expected 1", smp_acc);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (!smp_got && n < 20);
    n_checks++;
    if (n != int'(STG)) begin
      n_fail++; $display("FAIL latency_cycles: got %0d expected %0d", n, STG);
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
    n_checks++;
    if (smp_res !== {32'h8, 1'b0, 1'b0, 1'b0} || smp_res !== e) begin
      n_fail++; $display("FAIL latency_result: got %h expected %h", smp_res, {32'h8, 3'b000});
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [6] = '{32'h5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h10, 32'h8000_0000, 32'h0};
    logic [31:0] vb [6] = '{32'h3, 32'h0, 32'h1, 32'h11, 32'h1, 32'h0};
    logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    res_t        ve [6] = '{{32'h8, 3'b000}, {32'h0, 3'b101}, {32'h8000_0000, 3'b010},
                            {32'hFFFF_FFFF, 3'b000}, {32'h7FFF_FFFF, 3'b110}, {32'h0, 3'b101}};
    int          issued, got, cyc;
    res_t        e;
    issued = 0; got = 0; cyc = 0;
    out_ready = 1;
    while (got < 6 && cyc < 100) begin
      in_valid = (issued < 6);
      if (issued < 6) begin
        a = va[issued]; b = vb[issued]; c_in = vc[issued]; sub = vs[issued];
      end
      tick();
      if (smp_acc) issued++;
      if (smp_got) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
        n_checks++;
        if (smp_res !== ve[got]) begin
          n_fail++; $display("FAIL vector_%0d: got %h expected %h", got, smp_res, ve[got]);
        end
        n_checks++;
        if (smp_res !== e) begin
          n_fail++; $display("FAIL vector_model_%0d: got %h expected %h", got, smp_res, e);
        end
        got++;
      end
      cyc++;
    end
    in_valid = 0;
    n_checks++;
    if (got != 6) begin
      n_fail++; $display("FAIL vector_count: got %0d expected 6", got);
    end
  endtask

  task automatic test_backpressure();
    int   issued, got, cyc;
    logic held_valid, saw_stall;
    res_t held_res, e;
    issued = 0; got = 0; cyc = 0; held_valid = 0; saw_stall = 0; held_res = '0;
    c_in = 0; sub = 0;
    while (got < 8 && cyc < 200) begin
      out_ready = !(cyc >= 2 && cyc < 8);
      in_valid  = (issued < 8);
      a = 32'(issued); b = 32'(issued);
      tick();
      n_checks++;
      if (smp_in_ready !== ((issued - got) < int'(STG) || smp_out_ready)) begin
        n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b occupancy %0d", cyc, smp_in_ready, issued - got);
      end
      if (!smp_in_ready) saw_stall = 1;
      if (held_valid) begin
        n_checks++;
        if (smp_out_valid !== 1'b1 || smp_res !== held_res) begin
          n_fail++; $display("FAIL bp_hold cyc %0d: got %b/%h expected 1/%h", cyc, smp_out_valid, smp_res, held_res);
        end
      end
      held_valid = smp_out_valid && !smp_out_ready;
      held_res   = smp_res;
      if (smp_acc) issued++;
      if (smp_got) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
        n_checks++;
        if (smp_res !== e || smp_res.s !== 32'(2 * got)) begin
          n_fail++; $display("FAIL bp_result_%0d: got %h expected %h", got, smp_res, e);
        end
        got++;
      end
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    n_checks++;
    if (saw_stall !== 1'b1) begin
      n_fail++; $display("FAIL bp_stall_seen: got %b expected 1", saw_stall);
    end
    n_checks++;
    if (got != 8 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d left %0d expected 8 left 0", got, exp_q.size());
    end
  endtask

  task automatic test_random();
    int   issued, got, cyc, bad;
    logic held_valid;
    res_t held_res, e;
    issued = 0; got = 0; cyc = 0; bad = 0; held_valid = 0; held_res = '0;
    while (got < 1000 && cyc < 20000) begin
      in_valid  = (issued < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = pick_operand(); b = pick_operand();
      c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (smp_in_ready !== ((issued - got) < int'(STG) || smp_out_ready)) begin
        n_fail++; $display("FAIL rnd_in_ready cyc %0d: got %b occupancy %0d", cyc, smp_in_ready, issued - got);
      end
      if (held_valid) begin
        n_checks++;
        if (smp_out_valid !== 1'b1 || smp_res !== held_res) begin
          n_fail++; $display("FAIL rnd_hold cyc %0d: got %b/%h expected 1/%h", cyc, smp_out_valid, smp_res, held_res);
        end
      end
      held_valid = smp_out_valid && !smp_out_ready;
      held_res   = smp_res;
      if (smp_acc) issued++;
      if (smp_got) begin
        e = exp_q.size() > 0 ? exp_q.pop_front() : '1;
        n_checks++;
        if (smp_res !== e) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL rnd_result_%0d: got %h expected %h", got, smp_res, e);
        end
        got++;
      end
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    n_checks++;
    if (got != 1000 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rnd_count: got %0d left %0d expected 1000 left 0", got, exp_q.size());
    end
  endtask

  task automatic test_stage1();
    res_t q1[$];
    res_t e, r;
    int   issued, got, cyc, bad;
    logic acc, gotb;
    a1 = 16'h1234; b1 = 16'h0FFF; c_in1 = 1; sub1 = 0; out_ready1 = 1; in_valid1 = 1;
    @(negedge clk);
    n_checks++;
    if (in_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL s1_accept: got %b expected 1", in_ready1);
    end
    e = model({16'h0, a1}, {16'h0, b1}, c_in1, sub1, 16);
    @(posedge clk);
    #1;
    in_valid1 = 0;
    @(negedge clk);
    r = {16'h0, s1, c_out1, ovf1, zero1};
    n_checks++;
    if (out_valid1 !== 1'b1) begin
      n_fail++; $display("FAIL s1_latency: got out_valid %b expected 1", out_valid1);
    end
    n_checks++;
    if (r !== e || s1 !== 16'h2234) begin
      n_fail++; $display("FAIL s1_result: got %h expected %h", r, e);
    end
    @(posedge clk);
    #1;
    issued = 0; got = 0; cyc = 0; bad = 0;
    while (got < 200 && cyc < 4000) begin
      in_valid1  = (issued < 200) && ($urandom_range(0, 2) != 0);
      out_ready1 = ($urandom_range(0, 2) != 0);
      a1 = 16'($urandom); b1 = 16'($urandom);
      c_in1 = 1'($urandom_range(0, 1)); sub1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc  = in_valid1 && in_ready1;
      gotb = out_valid1 && out_ready1;
      n_checks++;
      if (in_ready1 !== ((issued - got) < 1 || out_ready1)) begin
        n_fail++; $display("FAIL s1_in_ready cyc %0d: got %b occupancy %0d", cyc, in_ready1, issued - got);
      end
      if (gotb) begin
        e = q1.size() > 0 ? q1.pop_front() : '1;
        r = {16'h0, s1, c_out1, ovf1, zero1};
        n_checks++;
        if (r !== e) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL s1_rnd_%0d: got %h expected %h", got, r, e);
        end
        got++;
      end
      if (acc) begin
        q1.push_back(model({16'h0, a1}, {16'h0, b1}, c_in1, sub1, 16));
        issued++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid1 = 0; out_ready1 = 1;
    n_checks++;
    if (got != 200) begin
      n_fail++; $display("FAIL s1_count: got %0d expected 200", got);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    out_ready = 1; c_in = 0; sub = 0;
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + 32'(i); b = 32'h1; in_valid = 1;
      tick();
    end
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if ({s, c_out, ovf, zero} !== 35'd0) begin
      n_fail++; $display("FAIL arst_outputs: got %h expected 0", {s, c_out, ovf, zero});
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (smp_out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL arst_stale: got %0d beats expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_random();
    test_stage1();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
